// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: memory-side responder for the LSU request channel.
// Serves one request at a time: word read / byte-masked write on an internal
// RAM, byte output for stores into the UART window, error response otherwise.
// The response is a one-cycle pulse issued LATENCY + 2 cycles after the request.
// Optional build macro LSU_MEM_BRIDGE_RAND_DELAY_EN adds 0-3 extra wait cycles
// chosen by an 8-bit LFSR.
module lsu_mem_bridge #(
    parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
    parameter int          RAM_WORDS = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        uart_valid,
    output logic [7:0]  uart_data,
    output logic        busy
);

    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
    localparam logic [31:0] UART_LO   = 32'h1000_0000;
    localparam logic [31:0] UART_HI   = 32'h1000_0fff;
    // Wide enough to hold LATENCY plus the optional 0-3 random extension.
    localparam int          CNT_W     = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_load;

    // Captured request; only meaningful once the FSM has left IDLE.
    logic [31:0]        addr_q;
    logic               wen_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wmask_q;

    logic [31:0]        mem [RAM_WORDS];

    logic [31:0]        offset;
    logic               ram_hit;
    logic               uart_hit;
    logic [IDX_W-1:0]   idx;
    logic               enter_resp;

    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q,   resp_err_d;
    logic               uart_valid_q, uart_valid_d;
    logic [7:0]         uart_data_q,  uart_data_d;

    // Size is informational only; the byte mask governs writes.
    logic               size_unused;
    assign size_unused = ^req_size;

`ifdef LSU_MEM_BRIDGE_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign cnt_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY);
`endif

    // Address decode on the captured request; 33-bit compare avoids wrap at the top of RAM.
    assign offset   = addr_q - RAM_BASE;
    assign ram_hit  = (addr_q >= RAM_BASE) && ({1'b0, offset} < RAM_BYTES);
    assign uart_hit = (addr_q >= UART_LO) && (addr_q <= UART_HI);
    assign idx      = offset[IDX_W+1:2];

    // State and wait-counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sample in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_load;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: response and UART values registered on the edge into RESP.
    always_comb begin
        enter_resp   = (state_q == S_WAIT) && (cnt_q == '0);
        resp_valid_d = enter_resp;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        uart_valid_d = 1'b0;
        uart_data_d  = uart_data_q;
        if (enter_resp) begin
            resp_rdata_d = 32'h0;
            if (ram_hit) begin
                if (!wen_q) resp_rdata_d = mem[idx];
            end else if (uart_hit) begin
                if (wen_q) begin
                    uart_valid_d = 1'b1;
                    uart_data_d  = wdata_q[{addr_q[1:0], 3'b000} +: 8];
                end
            end else begin
                resp_err_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            uart_valid_q <= 1'b0;
            uart_data_q  <= 8'h0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            uart_valid_q <= uart_valid_d;
            uart_data_q  <= uart_data_d;
        end
    end

    // Request capture; later changes on req_* are ignored until the next IDLE.
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    // Byte-masked RAM store; suppressed if reset lands on the commit edge.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && ram_hit && wen_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign uart_valid = uart_valid_q;
    assign uart_data  = uart_data_q;
    assign busy       = (state_q != S_IDLE) || (size_unused & 1'b0);

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Testbench for lsu_mem_bridge: directed cases plus randomized traffic,
// checked through a response scoreboard against a word-array memory model.
module tb_lsu_mem_bridge;

    localparam int          LAT  = 2;
    localparam int          PER  = 10;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b10;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        busy;

    lsu_mem_bridge #(.RAM_BASE(BASE), .RAM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .uart_valid(uart_valid), .uart_data(uart_data), .busy(busy)
    );

    always #(PER/2) clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      t;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  uexp_q[$];
    logic [31:0] mem_m [int];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 0;

    logic [31:0] pool [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0010, 32'h8000_0020,
                              32'h8000_0ABC, 32'h8000_1000, 32'h8000_3FF8, 32'h8000_3FFC};
    logic [31:0] errs [6] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h0FFF_FFFC,
                              32'h1000_1000, 32'h2000_0000, 32'hFFFF_FFFC};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a >= BASE) && (longint'(a) < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic bit is_uart(input logic [31:0] a);
        return (a >= 32'h1000_0000) && (a <= 32'h1000_0fff);
    endfunction

    // Issue one request, push its expected outcome, hold valid until the response.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input bit scramble);
        exp_t        e;
        bit          seen;
        int          wi;
        logic [31:0] word;
        @(negedge clock);
        chk("busy_before_req", {63'b0, busy}, 64'd0);
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_wmask = m;
        req_size  = (m == 4'b1111 || !w) ? 2'b10 : 2'b00;
        req_valid = 1'b1;
        e.t     = longint'($time) + (LAT + 2) * PER;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (is_ram(a)) begin
            wi = int'((a - BASE) >> 2);
            if (w) begin
                word = mem_m.exists(wi) ? mem_m[wi] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (m[i]) word[8*i +: 8] = d[8*i +: 8];
                mem_m[wi] = word;
            end else begin
                e.rdata = mem_m[wi];
            end
        end else if (is_uart(a)) begin
            if (w) uexp_q.push_back(d[{a[1:0], 3'b000} +: 8]);
        end else begin
            e.err = 1'b1;
        end
        exp_q.push_back(e);
        seen = 0;
        for (int k = 1; k <= LAT + 12 && !seen; k++) begin
            @(negedge clock);
            if (k == 1 && scramble) begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_wmask = 4'($urandom);
                req_wen   = ~req_wen;
            end
            if (k <= LAT + 2) chk("busy_during_req", {63'b0, busy}, 64'd1);
            if (resp_valid) seen = 1;
        end
        req_valid = 1'b0;
        if (!seen) fail("resp_timeout");
    endtask

    // Scoreboard monitor: every response and UART pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", {32'b0, resp_rdata}, {32'b0, e.rdata});
                    chk("resp_err", {63'b0, resp_err}, {63'b0, e.err});
                    chk("resp_time", longint'($time), e.t);
                end
            end else begin
                chk("resp_err_idle", {63'b0, resp_err}, 64'd0);
            end
            if (uart_valid) begin
                chk("uart_with_resp", {63'b0, resp_valid}, 64'd1);
                if (uexp_q.size() == 0) fail("unexpected_uart");
                else chk("uart_data", {56'b0, uart_data}, {56'b0, uexp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          sel;
        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", {32'b0, resp_rdata}, 64'd0);
        chk("rst_resp_err",   {63'b0, resp_err},   64'd0);
        chk("rst_uart_valid", {63'b0, uart_valid}, 64'd0);
        chk("rst_uart_data",  {56'b0, uart_data},  64'd0);
        chk("rst_busy",       {63'b0, busy},       64'd0);
        reset  = 1'b0;
        mon_en = 1;

        // Give every pool word a known value
        foreach (pool[i]) issue(pool[i], 1'b1, $urandom, 4'b1111, 1'b0);

        // Directed cases
        issue(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h8000_0010, 1'b1, 32'h0000_AA00, 4'b0010, 1'b1);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h1000_0000, 1'b1, 32'h0000_0041, 4'b0001, 1'b0);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h2000_0000, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h1000_0FFF, 1'b1, 32'h7700_0000, 4'b1000, 1'b0);
        issue(32'h1000_0004, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(32'h8000_4000, 1'b1, 32'h1111_1111, 4'b1111, 1'b0);
        issue(32'h8000_3FFC, 1'b0, 32'h0, 4'b0000, 1'b0);

        // Reset during WAIT of a store: nothing committed, no response
        @(negedge clock);
        req_addr = 32'h8000_0020; req_wen = 1'b1; req_wdata = 32'h1234_5678;
        req_wmask = 4'b1111; req_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("busy_after_reset", {63'b0, busy}, 64'd0);
        repeat (LAT + 4) @(negedge clock);
        issue(32'h8000_0020, 1'b0, 32'h0, 4'b0000, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = pool[$urandom_range(0, 7)];
            else if (sel < 8) a = 32'h1000_0000 | ($urandom & 32'hFFF);
            else              a = errs[$urandom_range(0, 5)];
            issue(a, 1'($urandom), $urandom, 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (LAT + 6) @(negedge clock);
        chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("uart_queue_drained", 64'(uexp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #(PER * 60000);
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Memory-side responder for the multi-cycle core's load/store unit.
- Accepts one request at a time on the LSU request channel: valid, addr, size, wen, wdata, wmask.
- Performs a word-wide read or byte-masked write on an internal RAM. Stores to the UART window are routed to a byte output.
- Returns a single-cycle response pulse with read data after a configurable latency. Load byte extraction stays in the LSU.

Parameters:
- RAM_BASE, 32'h8000_0000, byte address of RAM word 0.
- RAM_WORDS, 4096, RAM depth in 32-bit words; power of two.
- LATENCY, 2, wait cycles inserted between request capture and response (0 allowed).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present; held high by the requester until resp_valid.
- req_addr  in  32  byte address. Word-aligned for RAM; exact for UART.
- req_size  in  2  2'b10 = word, 2'b00 = byte; informational, wmask governs writes.
- req_wen  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data; byte lanes are already positioned by the requester.
- req_wmask  in  4  byte-enable, bit i = byte lane i.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read word, valid with resp_valid; 0 for stores.
- resp_err  out  1  with resp_valid: address hit neither RAM nor UART.
- uart_valid  out  1  one-cycle pulse, UART byte emitted.
- uart_data  out  8  UART byte, valid with uart_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: resp_valid = 0, resp_rdata = 0, resp_err = 0, uart_valid = 0, uart_data = 0, busy = 0; state IDLE, wait counter 0. RAM contents are not cleared.
- Address decode on the captured address:
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS; word index = (addr - RAM_BASE) >> 2.
  - UART hit: 32'h1000_0000 <= addr <= 32'h1000_0fff.
  - Anything else is an error.
- State machine:
  - IDLE: if req_valid, capture addr/wen/wdata/wmask, load counter = LATENCY, go WAIT. Requests are sampled only in IDLE.
  - WAIT: if counter == 0 go RESP, else decrement.
  - RESP: resp_valid = 1 for exactly this cycle, then go IDLE.
- Entering RESP (all registered on the edge into RESP):
  - RAM load: resp_rdata = RAM[index].
  - RAM store: bytes with wmask bit set are updated; the others are preserved.
  - UART store: uart_valid pulses; uart_data = wdata byte lane addr[1:0].
  - UART load: resp_rdata = 0.
  - Error: no memory or UART side effect; resp_err = 1, resp_rdata = 0.
  - wmask = 4'b0000 on a store: no bytes change; response still issued.
- Latency: req_valid high in cycle T gives resp_valid high in cycle T + LATENCY + 2. With LATENCY = 0, resp_valid is high in T+2.
- Outside RESP: resp_valid = 0, resp_err = 0. resp_rdata holds its last value.
- Requester rule: req_valid must be low in the cycle after resp_valid. The bridge returns to IDLE and re-samples there, so a still-high req_valid is taken as a new request. This is defined behaviour, not an error.
- Changes to req_* while not in IDLE are ignored; the captured copy is used.
- Reset mid-operation: return to IDLE next edge. No pending write or UART byte is performed; no response is issued.

Optional Feature:
- Macro: LSU_MEM_BRIDGE_RAND_DELAY_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advances every cycle.
  - Wait count loaded in IDLE = LATENCY + lfsr[1:0], giving 0-3 extra cycles.
  - Response ordering and side effects are unchanged.
- Undefined: the LFSR is absent and latency is fixed at LATENCY.

Test Plan:
- Store word 32'hDEADBEEF, wmask 4'b1111 to 32'h8000_0010, then load the same address -> second response returns resp_rdata = 32'hDEADBEEF, resp_err = 0.
- Store wdata 32'h0000_AA00, wmask 4'b0010 to 32'h8000_0010 after the first case -> a later load returns 32'hDEADAAEF.
- Store wdata 32'h0000_0041, wmask 4'b0001 to 32'h1000_0000 -> uart_valid pulses once with uart_data = 8'h41; RAM unchanged.
- Load from 32'h2000_0000 -> resp_valid with resp_err = 1, resp_rdata = 0; no state change anywhere.
- LATENCY = 2, req_valid rises in cycle 10 -> resp_valid high only in cycle 14; busy high in cycles 11-14.
- Reset asserted in WAIT of a store 32'h1234_5678 to 32'h8000_0020 -> no resp_valid; a later load of 32'h8000_0020 returns the prior contents.
